// File: rtl/wrr_arb_pkg.sv
// rtl/wrr_arb_pkg.sv - shared types, defaults and helpers for the WRR stream arbiter
package wrr_arb_pkg;

  localparam int DEF_N_REQ = 8;
  localparam int DEF_DATAW = 64;
  localparam int DEF_WGTW  = 4;
  localparam int MAX_REQ   = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  function automatic int onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/wrr_stream_arbiter_if.sv
// rtl/wrr_stream_arbiter_if.sv - requester streams, shared output stream and weights
interface wrr_stream_arbiter_if
  import wrr_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int DATAW = DEF_DATAW,
  parameter int WGTW  = DEF_WGTW
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       in_valid;
  logic [N_REQ-1:0]       in_ready;
  logic [N_REQ*DATAW-1:0] in_data;
  logic [N_REQ-1:0]       in_last;
  logic [N_REQ*WGTW-1:0]  weight;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATAW-1:0]       out_data;
  logic                   out_last;
  logic [IDW-1:0]         out_id;
  logic [N_REQ-1:0]       grant;

  modport slave (
    input  in_valid, in_data, in_last, weight, out_ready,
    output in_ready, out_valid, out_data, out_last, out_id, grant
  );

  modport master (
    output in_valid, in_data, in_last, weight, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_id, grant
  );

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - lowest requester strictly above the last grant, wrapping to the lowest overall
module rr_pick
  import wrr_arb_pkg::*;
#(
  parameter int N = DEF_N_REQ
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] last_grant,
  output logic [N-1:0] pick
);
  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0] w_above;
  logic [N-1:0] w_masked;
  logic [N-1:0] w_pick_masked;
  logic [N-1:0] w_pick_any;

  // last_grant is one-hot, so (lg | lg-1) covers it and everything below
  assign w_above       = ~(last_grant | (last_grant - ONE));
  assign w_masked      = req & w_above;
  assign w_pick_masked = w_masked & (~w_masked + ONE);
  assign w_pick_any    = req & (~req + ONE);
  assign pick          = (|w_masked) ? w_pick_masked : w_pick_any;

endmodule

// File: rtl/wrr_stream_arbiter.sv
// rtl/wrr_stream_arbiter.sv - packet-locked weighted round-robin mux with registered output
module wrr_stream_arbiter
  import wrr_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int DATAW = DEF_DATAW,
  parameter int WGTW  = DEF_WGTW
) (
  input logic                 clk,
  input logic                 rst_n,
  wrr_stream_arbiter_if.slave bus
);
  localparam int              IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [WGTW-1:0] W_ONE = WGTW'(1);

  state_e           r_state, w_state_nxt;
  logic [N_REQ-1:0] r_grant, w_grant_nxt;
  logic [N_REQ-1:0] r_last_grant, w_last_grant_nxt;
  logic [N_REQ-1:0] w_pick;
  logic [WGTW-1:0]  r_credit, w_credit_nxt;
  logic [WGTW-1:0]  w_pick_wgt;
  logic [IDW-1:0]   w_own_idx, w_pick_idx, w_last_idx;
  logic             w_can_load, w_accept, w_own_last;

  logic             r_out_valid;
  logic             r_out_last;
  logic [DATAW-1:0] r_out_data;
  logic [IDW-1:0]   r_out_id;

  rr_pick #(.N(N_REQ)) u_pick (
    .req        (bus.in_valid),
    .last_grant (r_last_grant),
    .pick       (w_pick)
  );

  assign w_own_idx  = IDW'(onehot_to_idx(MAX_REQ'(r_grant)));
  assign w_pick_idx = IDW'(onehot_to_idx(MAX_REQ'(w_pick)));
  assign w_last_idx = IDW'(onehot_to_idx(MAX_REQ'(r_last_grant)));
  assign w_pick_wgt = bus.weight[w_pick_idx*WGTW +: WGTW];
  assign w_own_last = bus.in_last[w_own_idx];

  // the output register can take a beat when empty or being drained this cycle
  assign w_can_load = !r_out_valid || bus.out_ready;
  assign w_accept   = (r_state == LOCKED) && bus.in_valid[w_own_idx] && w_can_load;

  always_comb begin
    bus.in_ready = '0;
    if (r_state == LOCKED && w_can_load) bus.in_ready = r_grant;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_last_grant_nxt = r_last_grant;
    w_credit_nxt     = r_credit;
    case (r_state)
      IDLE: begin
        // in IDLE last_grant still names the previous owner
        if (r_credit != '0 && bus.in_valid[w_last_idx]) begin
          w_state_nxt  = LOCKED;
          w_grant_nxt  = r_last_grant;
          w_credit_nxt = r_credit - W_ONE;
        end else if (|bus.in_valid) begin
          w_state_nxt  = LOCKED;
          w_grant_nxt  = w_pick;
          w_credit_nxt = (w_pick_wgt == '0) ? '0 : w_pick_wgt - W_ONE;
        end else begin
          w_credit_nxt = '0;
        end
      end
      LOCKED: begin
        if (w_accept && w_own_last) begin
          w_state_nxt      = IDLE;
          w_grant_nxt      = '0;
          w_last_grant_nxt = r_grant;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last_grant <= {1'b1, {(N_REQ-1){1'b0}}};
      r_credit     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_credit     <= w_credit_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_last  <= w_own_last;
      r_out_data  <= bus.in_data[w_own_idx*DATAW +: DATAW];
      r_out_id    <= w_own_idx;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.out_data  = r_out_data;
  assign bus.out_id    = r_out_id;
  assign bus.grant     = r_grant;

endmodule

// File: doc/wrr_stream_arbiter.md
# wrr_stream_arbiter

Weighted round-robin arbiter and multiplexer for N_REQ valid/ready streams sharing one output stream. It holds a grant for a whole packet, up to the `in_last` beat. It can re-grant the same requester for up to a programmable number of consecutive packets. Output is fully registered. It sits between per-source packet queues and a shared downstream bus, and replaces the purely combinational next-ready computation used so far.

## Interface
- `N_REQ`, 8, number of requesters, ≥2
- `DATAW`, 64, data width per stream
- `WGTW`, 4, weight field width
- `clk` in 1 — sole clock, rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `in_valid` in N_REQ — per-requester beat valid
- `in_ready` out N_REQ — per-requester beat accept
- `in_data` in N_REQ*DATAW — requester i at bits [i*DATAW +: DATAW]
- `in_last` in N_REQ — final beat of packet
- `weight` in N_REQ*WGTW — consecutive-packet quota per requester; 0 treated as 1; quasi-static
- `out_valid` out 1, `out_ready` in 1, `out_data` out DATAW, `out_last` out 1
- `out_id` out $clog2(N_REQ) — index of the source of the current output beat
- `grant` out N_REQ — one-hot current owner; all-zero in IDLE

## Operation
- States: IDLE, LOCKED.
- IDLE, choosing the next owner:
  - If `credit` > 0 and `in_valid[owner]` is high, re-grant the same owner and decrement `credit`.
  - Otherwise, pick the lowest valid index strictly above `last_grant`, wrapping to the lowest valid index overall. Load `credit = max(weight[pick],1) - 1`, sampled only at this point.
  - If nothing is valid, stay in IDLE. `last_grant` is unchanged and `credit` is cleared (the quota is forfeited).
- LOCKED: `in_ready[owner] = !out_valid || out_ready`. All other `in_ready` are 0.
  - An accepted beat loads the output register with `out_data`, `out_last` and `out_id`.
  - Accepting a beat with `in_last` high moves to IDLE and updates `last_grant` to the owner.
- Output register:
  - It may load in the same cycle it is drained (`out_valid && out_ready`).
  - `out_valid` clears when the register is drained with no new load.
- Upstream must not drop `in_valid` without a handshake. If it does, the arbiter keeps the lock and waits; it never times out.
- `weight` changes while LOCKED take effect at the next fresh grant.

## Timing
- Reset values:
  - state IDLE
  - `last_grant` = one-hot bit N_REQ-1, so requester 0 wins first
  - `credit` = 0
  - `in_ready`, `grant`, `out_valid`, `out_last`, `out_data` and `out_id` all 0
- Reset mid-packet drops the partial packet. `out_valid` falls asynchronously with `rst_n`.
- Latency from an idle arbiter:
  - in_valid seen at cycle 0 → grant and `in_ready` at cycle 1 → `out_valid` at cycle 2.
- Throughput: 1 beat/cycle within a packet while `out_ready` = 1.
- There is exactly one IDLE bubble cycle between packets, including back-to-back re-grants.
- Single-beat packets (`in_valid` and `in_last` together) therefore use at most 1 beat per 2 cycles.
- Simultaneous events:
  - Drain and load in the same cycle: a new beat is accepted with no bubble.
  - The owner's last beat with `out_ready` low: the beat is held and IDLE is entered only once the beat is accepted.

## Structure
- Package `wrr_arb_pkg`:
  - `state_e` {IDLE, LOCKED}
  - `onehot_to_idx` function
  - default parameter constants
- Sub-module `rr_pick`: combinational masked-above-pointer picker with an unmasked fallback. Ports: `req`, `last_grant`, one-hot `pick`.
- Top level holds the FSM, `credit` counter, `last_grant` register, data mux and output register.

## Test plan
- **Reset priority:** reset, then `in_valid` = 8'hFF with 1-beat packets and all weights 1 → `out_id` sequence 0,1,…,7,0. `out_valid` first rises 2 cycles after reset release.
- **Packet lock:**
  - Requester 3 sends a 4-beat packet while requester 5 is valid → 4 consecutive beats with `out_id` = 3.
  - `out_last` on beat 4, then `out_id` = 5.
  - `in_ready[5]` stays 0 throughout the lock.
- **Weights:** `weight[2]` = 3, `weight[6]` = 1, both continuously valid, 1-beat packets → `out_id` pattern 2,2,2,6,2,2,2,6.
- **Backpressure:**
  - `out_ready` toggles 1010… during an 8-beat packet → no beat lost or duplicated, and data order is preserved.
  - `in_ready[owner]` = 0 whenever `out_valid` = 1 and `out_ready` = 0.
- **Forfeit and wrap:**
  - `weight[7]` = 4 and requester 7 drops after 1 packet while requester 1 is valid → requester 1 is granted next (wrap past index 7).
  - `credit` reads 0 after that grant.
- **Reset mid-packet:** assert `rst_n` low during beat 2 of 5 → `out_valid` = 0 and `in_ready` = 0 immediately. After release, requester 0 has priority again.
